// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  // FSM encoding; the unused code 2'd3 is treated as IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Step-counter width for a given operand width: $clog2(width), never below 1 bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one add per clock, WIDTH steps per product,
// unsigned or two's-complement operands selected per operation.
//
// state | meaning
// IDLE  | waiting for start, product holds last result
// CALC  | one shift-add step per edge, busy=1
// FIN   | product valid, done=1 for this cycle; a new start is accepted here
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // One guard bit above the 2*WIDTH product so the upper add never loses its carry.
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_add;
  logic [2*WIDTH:0]   acc_step;

  // Datapath for one CALC step: conditional add into the upper half, then shift.
  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    acc_add   = mplr_q[0] ? {upper_sum, acc_q[WIDTH-1:0]} : acc_q;
    acc_step  = acc_add >> 1;
  end

  // Next-state, operand capture and result fix-up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      ST_CALC: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_FIN;
          product_d = neg_q ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
        end
      end
      default: begin
        // IDLE, FIN and the unused encoding all accept a new request.
        if (start) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          acc_d   = '0;
          // Most-negative operand negates to itself, which read unsigned is its magnitude.
          mcand_d = (signed_mode && a[WIDTH-1]) ? -a : a;
          mplr_d  = (signed_mode && b[WIDTH-1]) ? -b : b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy    = (state_q == ST_CALC);
    done    = (state_q == ST_FIN);
    product = product_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=4): directed vectors with fixed
// expected products, back-to-back starts, mid-operation reset, random vectors.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] p;
  } vec_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  logic [2*W-1:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic product truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    longint p;
    if (sm) p = longint'($signed(x)) * longint'($signed(y));
    else    p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs; record an expected result when the DUT will accept.
  task automatic issue(input logic st, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sm, input logic [2*W-1:0] e, output logic took);
    start       = st;
    a           = x;
    b           = y;
    signed_mode = sm;
    took        = st && !busy && !rst;
    if (took) exp_q.push_back('{prod: e, cyc: cyc + 1});
    @(negedge clk);
  endtask

  task automatic drain();
    logic t;
    issue(1'b0, '0, '0, 1'b0, '0, t);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: compares every done against the scoreboard, checks latency,
  // busy length, single-cycle done and product stability between results.
  int   run = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run       = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("busy_cycles", run, W);
        check("done_twice", prev_done, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: product %0h with nothing pending", product);
        end else begin
          e = exp_q.pop_front();
          check("product", product, e.prod);
          check("latency", cyc - e.cyc, W);
          last_prod = e.prod;
        end
        run = 0;
      end else begin
        check("product_held", product, last_prod);
        run = busy ? run + 1 : 0;
      end
      prev_done = done;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t dir [9];
    logic took;
    logic [W-1:0] x, y;
    logic sm;
    int accepted;

    dir[0] = '{4'b1100, 4'b1100, 1'b0, 8'h90};
    dir[1] = '{4'b1111, 4'b0110, 1'b0, 8'h5A};
    dir[2] = '{4'b0000, 4'b0110, 1'b0, 8'h00};
    dir[3] = '{4'b0001, 4'b0011, 1'b0, 8'h03};
    dir[4] = '{4'b1100, 4'b1100, 1'b1, 8'h10};
    dir[5] = '{4'b1111, 4'b0110, 1'b1, 8'hFA};
    dir[6] = '{4'b1000, 4'b1000, 1'b1, 8'h40};
    dir[7] = '{4'b1000, 4'b0111, 1'b1, 8'hC8};
    dir[8] = '{4'b1111, 4'b1111, 1'b0, 8'hE1};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Directed single operations
    foreach (dir[i]) begin
      issue(1'b1, dir[i].a, dir[i].b, dir[i].sm, dir[i].p, took);
      check("directed_accept", took, 1);
      drain();
    end

    // Start held high; operands scrambled while busy must not disturb results
    for (int i = 0; i < 22; i++) begin
      x  = busy ? W'($urandom) : 4'b0110;
      y  = busy ? W'($urandom) : 4'b0110;
      sm = busy ? 1'($urandom) : 1'b0;
      issue(1'b1, x, y, sm, 8'h24, took);
    end
    drain();

    // Asynchronous reset two edges into an operation
    issue(1'b1, 4'b0110, 4'b0111, 1'b0, 8'h2A, took);
    issue(1'b0, '0, '0, 1'b0, '0, took);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_product", product, 0);
    exp_q.delete();
    last_prod = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    issue(1'b1, 4'b0100, 4'b0100, 1'b0, 8'h10, took);
    drain();

    // Random vectors, including starts during the done cycle and while busy
    accepted = 0;
    for (int i = 0; i < 5000 && accepted < 200; i++) begin
      x  = W'($urandom);
      y  = W'($urandom);
      sm = 1'($urandom);
      issue($urandom_range(0, 3) != 0, x, y, sm, ref_mul(x, y, sm), took);
      if (took) accepted++;
    end
    check("random_count", accepted, 200);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
